// File: rtl/dtag_assoc.sv
// dtag_assoc: WAYS-way set-associative D-cache tag store.
// It does the tag compare, hit-way encode and victim selection, and runs the
// invalidate sweep. Lookups are a single registered stage. The tag arrays have
// an asynchronous read so that lk_req at one edge is answered at the next edge.
// Optional feature macro: DTAG_PARITY_EN. When defined, each entry stores an
// even-parity bit that is checked on lookup.
module dtag_assoc #(
  parameter int NL   = 256,
  parameter int LSS  = $clog2(NL),
  parameter int LSH  = LSS + 4,
  parameter int PSL  = LSH + 1,
  parameter int TS   = 2 + (32 - PSL),
  parameter int WAYS = 2,
  parameter int WB   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              nGCLK,
  input  logic              nRESET,
  input  logic              lk_req,
  input  logic [31:0]       lk_addr,
  output logic              lk_vld,
  output logic              lk_hit,
  output logic [WB-1:0]     lk_way,
  output logic              lk_dirty,
  output logic [31-PSL:0]   lk_vtag,
  input  logic              wr_ena,
  input  logic [LSS-1:0]    wr_line,
  input  logic [WB-1:0]     wr_way,
  input  logic [TS-1:0]     wr_data,
  input  logic              inv_start,
  output logic              inv_busy,
  output logic              inv_done,
  output logic              lk_perr
);
  localparam int TW = 32 - PSL;
`ifdef DTAG_PARITY_EN
  localparam int EW = TS + 1;
`else
  localparam int EW = TS;
`endif

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t          state_q, state_d;
  logic [LSS-1:0]  idx_q, idx_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [WB-1:0]   rr_q, rr_d;
  logic            vld_q, vld_d, hit_q, hit_d, dirty_q, dirty_d, perr_q, perr_d;
  logic [WB-1:0]   way_q, way_d;
  logic [TW-1:0]   vtag_q, vtag_d;

  logic [LSS-1:0]  lk_line;
  logic [TW-1:0]   lk_tag;
  logic            sweeping, wr_act;
  logic [LSS-1:0]  we_line;
  logic [EW-1:0]   wr_ent, we_data;
  logic [WAYS-1:0] we_way, ent_v, ent_d, ent_hit, ent_bad;
  logic [TW-1:0]   ent_tag [WAYS];
  logic            unused_addr_bits;

  assign lk_line  = lk_addr[LSH:5];
  assign lk_tag   = lk_addr[31:PSL];
  assign unused_addr_bits = ^lk_addr[4:0];
  assign sweeping = (state_q == S_SWEEP);
  // Controller writes are dropped while the sweep owns the write port.
  assign wr_act   = wr_ena && !sweeping;
`ifdef DTAG_PARITY_EN
  assign wr_ent   = {^wr_data, wr_data};
`else
  assign wr_ent   = wr_data;
`endif
  // The sweep writes all-zero entries (even parity of zero is zero).
  assign we_line  = sweeping ? idx_q : wr_line;
  assign we_data  = sweeping ? '0 : wr_ent;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [EW-1:0] ram_q [NL];
    logic [EW-1:0] ent;

    assign we_way[gi] = sweeping || (wr_act && (wr_way == WB'(gi)));

    // Per-way tag array write port; contents are never reset.
    always_ff @(posedge nGCLK) begin
      if (we_way[gi]) ram_q[we_line] <= we_data;
    end

    // Write-first: a same-edge write to the looked-up line overrides the stored entry.
    assign ent = (wr_act && (wr_line == lk_line) && (wr_way == WB'(gi))) ? wr_ent : ram_q[lk_line];
`ifdef DTAG_PARITY_EN
    assign ent_bad[gi] = ^ent;
`else
    assign ent_bad[gi] = 1'b0;
`endif
    assign ent_d[gi]   = ent[TS-1];
    assign ent_v[gi]   = ent[TS-2] && !ent_bad[gi];
    assign ent_tag[gi] = ent[TW-1:0];
    assign ent_hit[gi] = ent_v[gi] && (ent[TW-1:0] == lk_tag);
  end

  logic          hit_c, found_c, sel_dirty_c;
  logic [WB-1:0] hway_c, vic_c, sel_c;
  logic [TW-1:0] sel_tag_c;

  // Hit-way encode and victim choice: lowest invalid way, else round-robin pointer.
  always_comb begin
    hit_c   = 1'b0;
    found_c = 1'b0;
    hway_c  = '0;
    vic_c   = rr_q;
    for (int w = 0; w < WAYS; w++) begin
      if (ent_hit[w]) begin
        hit_c  = 1'b1;
        hway_c = WB'(w);
      end
      if (!ent_v[w] && !found_c) begin
        found_c = 1'b1;
        vic_c   = WB'(w);
      end
    end
    sel_c       = hit_c ? hway_c : vic_c;
    sel_dirty_c = ent_d[sel_c];
    sel_tag_c   = ent_tag[sel_c];
  end

  // Next lookup outputs; they hold when no request, and read as a miss during a sweep.
  always_comb begin
    vld_d   = lk_req;
    hit_d   = hit_q;
    way_d   = way_q;
    dirty_d = dirty_q;
    vtag_d  = vtag_q;
    perr_d  = perr_q;
    rr_d    = rr_q;
    if (lk_req) begin
      if (sweeping) begin
        hit_d   = 1'b0;
        way_d   = '0;
        dirty_d = 1'b0;
        vtag_d  = '0;
        perr_d  = 1'b0;
      end else begin
        hit_d   = hit_c;
        way_d   = sel_c;
        dirty_d = sel_dirty_c;
        vtag_d  = sel_tag_c;
        perr_d  = |ent_bad;
        if (!hit_c && (&ent_v)) rr_d = (rr_q == WB'(WAYS - 1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

  // Sweep FSM next state: NL cycles of clearing, then a one-cycle done pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LSS'(NL - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (inv_start) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset aborts any sweep and restarts it from line 0.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_SWEEP;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      rr_q    <= '0;
      vld_q   <= 1'b0;
      hit_q   <= 1'b0;
      way_q   <= '0;
      dirty_q <= 1'b0;
      vtag_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      vld_q   <= vld_d;
      hit_q   <= hit_d;
      way_q   <= way_d;
      dirty_q <= dirty_d;
      vtag_q  <= vtag_d;
      perr_q  <= perr_d;
    end
  end

  assign lk_vld   = vld_q;
  assign lk_hit   = hit_q;
  assign lk_way   = way_q;
  assign lk_dirty = dirty_q;
  assign lk_vtag  = vtag_q;
  assign inv_busy = busy_q;
  assign inv_done = done_q;
`ifdef DTAG_PARITY_EN
  assign lk_perr  = perr_q;
`else
  assign lk_perr  = 1'b0;
`endif

endmodule
